// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared defaults and width helper for the register write arbiter
package reg_write_arbiter_pkg;
    localparam int DEF_N       = 32;
    localparam int DEF_NUM_VAL = 4;
    localparam int DEF_NUM_REQ = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant among NUM_REQ requesters, search starts at ptr
// ports: clk, rst (sync, active-high); req requests; advance moves ptr past the winner;
//        gnt one-hot-or-zero grant; gnt_idx index of the winner
module rr_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PW = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_idx
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] cand [NUM_REQ];
    logic          hit;

    // cand[o] is requester (ptr + o) mod NUM_REQ, with one extra bit to avoid overflow
    for (genvar o = 0; o < NUM_REQ; o++) begin : g_cand
        logic [PW:0] s;
        assign s       = {1'b0, ptr} + (PW+1)'(o);
        assign cand[o] = s >= (PW+1)'(NUM_REQ) ? PW'(s - (PW+1)'(NUM_REQ)) : PW'(s);
    end

    // scanning from the far end lets the nearest valid requester overwrite the rest
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        for (int o = NUM_REQ - 1; o >= 0; o--)
            if (req[cand[o]]) begin
                hit     = 1'b1;
                gnt_idx = cand[o];
            end
    end

    assign gnt = hit ? NUM_REQ'(1) << gnt_idx : '0;

    always_ff @(posedge clk)
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin shares the write port of a multi-lane register bank
// ports: clk, rst (sync, active-high); req_valid/req_idx/req_data packed per requester;
//        req_ready one-hot grant (comb); reg_d/reg_ena registered bank write bus;
//        err_idx sticky out-of-range flag; busy = OR of req_valid (comb)
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_VAL = DEF_NUM_VAL,
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = clog2(NUM_VAL),
    localparam int PW     = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [NUM_REQ*N-1:0]     req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_VAL*N-1:0]     reg_d,
    output logic [NUM_VAL-1:0]       reg_ena,
    output logic                     err_idx,
    output logic                     busy
);
    logic [PW-1:0]        gnt_idx;
    logic                 xfer;
    logic [IDX_W-1:0]     sel_idx;
    logic [N-1:0]         sel_data;
    logic                 oob;
    logic [NUM_VAL-1:0]   nxt_ena;
    logic [NUM_VAL*N-1:0] nxt_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (xfer),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign busy     = |req_valid;
    assign xfer     = |req_ready;
    assign sel_idx  = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];
    assign sel_data = req_data[int'(gnt_idx)*N +: N];
    // widened compare stays meaningful when NUM_VAL is a power of two (never true then)
    assign oob      = xfer && ({1'b0, sel_idx} >= (IDX_W+1)'(NUM_VAL));

    // an out-of-range index matches no lane, so it is consumed without a write
    for (genvar k = 0; k < NUM_VAL; k++) begin : g_lane
        assign nxt_ena[k]       = xfer && sel_idx == IDX_W'(k);
        assign nxt_d[k*N +: N]  = nxt_ena[k] ? sel_data : '0;
    end

    always_ff @(posedge clk)
        if (rst) begin
            reg_ena <= '0;
            reg_d   <= '0;
            err_idx <= 1'b0;
        end else begin
            reg_ena <= nxt_ena;
            reg_d   <= nxt_d;
            if (oob) err_idx <= 1'b1;
        end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;
    localparam int NR = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req_valid = '0;
    logic [5:0]   req_idx = '0;
    logic [95:0]  req_data = '0;

    logic [2:0]   rdy4, rdy3;
    logic [127:0] d4;
    logic [95:0]  d3;
    logic [3:0]   ena4;
    logic [2:0]   ena3;
    logic         err4, err3, busy4, busy3;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    reg_write_arbiter #(.N(32), .NUM_VAL(4), .NUM_REQ(NR)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data),
        .req_ready(rdy4), .reg_d(d4), .reg_ena(ena4), .err_idx(err4), .busy(busy4)
    );

    reg_write_arbiter #(.N(32), .NUM_VAL(3), .NUM_REQ(NR)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data),
        .req_ready(rdy3), .reg_d(d3), .reg_ena(ena3), .err_idx(err3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // first valid requester scanning p, p+1, ... modulo NR; -1 when none
    function automatic int pick(input logic [2:0] v, input int p);
        for (int o = 0; o < NR; o++)
            if (v[(p + o) % NR]) return (p + o) % NR;
        return -1;
    endfunction

    function automatic logic [127:0] lanes(input int lane, input logic [31:0] v);
        logic [127:0] r;
        r = '0;
        if (lane >= 0) r[lane*32 +: 32] = v;
        return r;
    endfunction

    int          m_ptr = 0;
    int          m_lane4 = -1;
    int          m_lane3 = -1;
    logic [31:0] m_data = '0;
    logic        m_err3 = 1'b0;
    int          g;
    logic [31:0] bank [4];

    always_comb g = pick(req_valid, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_ptr   <= 0;
            m_lane4 <= -1;
            m_lane3 <= -1;
            m_err3  <= 1'b0;
        end else if (g >= 0) begin
            m_ptr   <= (g + 1) % NR;
            m_lane4 <= int'(req_idx[g*2 +: 2]);
            m_lane3 <= req_idx[g*2 +: 2] < 2'd3 ? int'(req_idx[g*2 +: 2]) : -1;
            m_data  <= req_data[g*32 +: 32];
            if (req_idx[g*2 +: 2] == 2'd3) m_err3 <= 1'b1;
        end else begin
            m_lane4 <= -1;
            m_lane3 <= -1;
        end
    end

    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (ena4[k]) bank[k] <= d4[k*32 +: 32];

    always @(negedge clk)
        if (chk_en) begin
            chk("ready4", rdy4, g < 0 ? 3'b000 : 3'(1 << g));
            chk("ready3", rdy3, g < 0 ? 3'b000 : 3'(1 << g));
            chk("busy4", busy4, |req_valid);
            chk("busy3", busy3, |req_valid);
            chk("ena4", ena4, m_lane4 < 0 ? 4'b0 : 4'(1 << m_lane4));
            chk("d4", d4, lanes(m_lane4, m_data));
            chk("ena3", ena3, m_lane3 < 0 ? 3'b0 : 3'(1 << m_lane3));
            chk("d3", d3, lanes(m_lane3, m_data));
            chk("err4", err4, 1'b0);
            chk("err3", err3, m_err3);
        end

    initial begin
        int gg;
        // reset with everyone requesting
        rst = 1'b1;
        req_valid = 3'b111;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_ena", ena4, 4'b0);
        chk("rst_d", d4, 128'b0);
        chk("rst_err", err3, 1'b0);
        chk("rst_first_grant", rdy4, 3'b001);
        step();

        // single write from requester 1 to lane 2
        req_valid = 3'b010;
        req_idx[3:2] = 2'd2;
        req_data[63:32] = 32'hDEADBEEF;
        #1;
        chk("single_ready", rdy4, 3'b010);
        step();
        req_valid = '0;
        #1;
        chk("single_ena", ena4, 4'b0100);
        chk("single_d", d4, {32'h0, 32'hDEADBEEF, 64'h0});
        step();
        chk("single_ena_off", ena4, 4'b0);

        // rotation with all three held valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 3'b111;
        req_idx = 6'b10_01_00;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rot_ready", rdy4, 3'b001 << (c % 3));
            step();
            chk("rot_onehot", $onehot(ena4), 1'b1);
        end

        // pointer wraps to 0 and skips idle requester 1
        req_valid = 3'b101;
        #1;
        chk("wrap_ready0", rdy4, 3'b001);
        step();
        req_valid = 3'b100;
        #1;
        chk("skip_ready2", rdy4, 3'b100);
        step();
        req_valid = '0;

        // same-lane collision: last granted write wins
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 3'b011;
        req_idx = 6'b00_11_11;
        req_data[31:0] = 32'h11;
        req_data[63:32] = 32'h22;
        #1;
        chk("coll_ready0", rdy4, 3'b001);
        step();
        req_valid = 3'b010;
        #1;
        chk("coll_ready1", rdy4, 3'b010);
        step();
        req_valid = '0;
        chk("coll_bank_first", bank[3], 32'h11);
        step();
        chk("coll_bank_last", bank[3], 32'h22);

        // out-of-range index on the 3-lane instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 3'b001;
        req_idx = 6'b00_00_11;
        #1;
        chk("oob_ready", rdy3, 3'b001);
        step();
        req_valid = '0;
        chk("oob_ena", ena3, 3'b0);
        chk("oob_err", err3, 1'b1);
        repeat (3) step();
        chk("oob_err_sticky", err3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("oob_err_cleared", err3, 1'b0);

        // randomized traffic obeying the hold rule
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                gg = g;
                step();
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i] && i != gg) begin
                        if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
                    end else begin
                        req_valid[i] = 1'($urandom_range(1));
                        req_idx[i*2 +: 2] = 2'($urandom_range(3));
                        req_data[i*32 +: 32] = $urandom;
                    end
                end
            end
        end
        req_valid = '0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
